// File: rtl/ac_sensor_link_pkg.sv
// Purpose: shared FSM state encoding and frame constants for the sensor link.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ac_sensor_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_CS_SETUP = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_CS_HOLD  = 3'd4,
        ST_UPDATE   = 3'd5
    } state_t;

    // Every frame opens with a fixed marker bit, so a silent bus (all zeros)
    // can never be mistaken for a valid reading.
    localparam logic MARKER = 1'b1;

    // Frame = marker + data + parity.
    localparam int FRAME_OVERHEAD = 2;

endpackage

// File: rtl/ac_sclk_gen.sv
// Purpose: half-period timer and serial-clock generator for the sensor bus.
// Latency: strobes are combinational from the count; sclk_o is registered.
// Backpressure: none; runs freely whenever run_i is high, idles cleared otherwise.
//
// Ports:
//   clk_i, rst_n_i  clock / async active-low reset
//   run_i           count half-periods; counter held at 0 while low
//   toggle_i        let sclk toggle on half-period boundaries; sclk held low while low
//   sclk_o          serial clock level
//   rise_o, fall_o  sclk_o goes high / low at the next clock edge
//   half_done_o     last cycle of the current half-period
module ac_sclk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run_i,
    input  logic toggle_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o,
    output logic half_done_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    assign half_done_o = run_i && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_o      = half_done_o && toggle_i && !sclk_q;
    assign fall_o      = half_done_o && toggle_i &&  sclk_q;
    assign sclk_o      = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (half_done_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (!run_i || !toggle_i) begin
            sclk_d = 1'b0;
        end else if (half_done_o) begin
            sclk_d = !sclk_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/ac_sensor_link.sv
// Purpose: polls two temperature sensors over a shared 3-wire bus, publishes checked 6-bit readings.
// Latency: one poll = 36*CLK_DIV cycles of bus activity, results + valid_o in the following cycle.
// Backpressure: none; consumers may sample s1_o/s2_o at any time, valid_o is a 1-cycle strobe.
//
// Ports:
//   clk_i, rst_n_i       clock / async active-low reset
//   enable_i             polling enable (looked at only between polls)
//   sdo_i                shared sensor data, sampled when sclk_o rises
//   sclk_o               serial clock, idles low
//   cs1_n_o, cs2_n_o     per-sensor chip selects, active low, never both low
//   s1_o, s2_o           last good reading per sensor
//   valid_o, err_ch_o    poll-complete strobe and per-channel frame error
//   busy_o               high from poll start through the valid_o cycle
module ac_sensor_link
    import ac_sensor_link_pkg::*;
#(
    parameter int DATA_W        = 6,
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 100000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              sdo_i,
    output logic              sclk_o,
    output logic              cs1_n_o,
    output logic              cs2_n_o,
    output logic [DATA_W-1:0] s1_o,
    output logic [DATA_W-1:0] s2_o,
    output logic              valid_o,
    output logic [1:0]        err_ch_o,
    output logic              busy_o
);

    localparam int FRAME_BITS = DATA_W + FRAME_OVERHEAD;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int PW         = $clog2(SAMPLE_PERIOD);

    state_t                  state_q, state_d;
    logic                    chan_q, chan_d;        // 0 = sensor 1, 1 = sensor 2
    logic [PW-1:0]           per_q, per_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   shreg_q, frame1_q;
    logic [DATA_W-1:0]       s1_q, s1_d, s2_q, s2_d;
    logic [1:0]              err_q, err_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    cs1_n_q, cs1_n_d, cs2_n_q, cs2_n_d;

    logic                    run, toggle;
    logic                    sclk_rise, sclk_fall, half_done;
    logic                    ok1, ok2;

    assign run    = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_CS_HOLD);
    assign toggle = (state_q == ST_SHIFT);

    ac_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .run_i       (run),
        .toggle_i    (toggle),
        .sclk_o      (sclk_o),
        .rise_o      (sclk_rise),
        .fall_o      (sclk_fall),
        .half_done_o (half_done)
    );

    // Marker present and even parity over data+parity.
    function automatic logic frame_good(input logic [FRAME_BITS-1:0] f);
        return (f[FRAME_BITS-1] == MARKER) && ((^f[FRAME_BITS-2:0]) == 1'b0);
    endfunction

    assign ok1 = frame_good(frame1_q);
    assign ok2 = frame_good(shreg_q);

    // Next-state / control
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        per_d   = per_q + PW'(1);
        unique case (state_q)
            ST_IDLE: begin
                per_d = '0;
                if (enable_i) begin
                    state_d = ST_CS_SETUP;
                    chan_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    per_d   = '0;
                end else if (per_q == PW'(SAMPLE_PERIOD - 1)) begin
                    // Reload on start keeps poll starts exactly SAMPLE_PERIOD apart.
                    state_d = ST_CS_SETUP;
                    chan_d  = 1'b0;
                    per_d   = '0;
                end
            end
            ST_CS_SETUP: begin
                if (half_done) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // The last falling edge ends the frame with sclk back low.
                if (sclk_fall && (bit_cnt_q == BW'(FRAME_BITS - 1))) state_d = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                if (half_done) begin
                    if (!chan_q) begin
                        chan_d  = 1'b1;
                        state_d = ST_CS_SETUP;
                    end else begin
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                if (enable_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                    per_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                per_d   = '0;
            end
        endcase
    end

    // Bit counter and registered outputs, derived from the next state so
    // the bus pins and status flags are glitch-free flop outputs.
    always_comb begin
        bit_cnt_d = '0;
        if (state_q == ST_SHIFT) begin
            bit_cnt_d = sclk_fall ? bit_cnt_q + BW'(1) : bit_cnt_q;
        end

        cs1_n_d = !(((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT)) && !chan_d);
        cs2_n_d = !(((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT)) &&  chan_d);
        busy_d  = (state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) ||
                  (state_d == ST_CS_HOLD)  || (state_d == ST_UPDATE);
        valid_d = (state_d == ST_UPDATE);

        s1_d  = s1_q;
        s2_d  = s2_q;
        err_d = err_q;
        // Entering UPDATE: sensor 2's frame is still in the shift register,
        // sensor 1's was parked in frame1_q. Errored channels keep old data.
        if ((state_q == ST_CS_HOLD) && (state_d == ST_UPDATE)) begin
            err_d = {!ok2, !ok1};
            if (ok1) s1_d = frame1_q[DATA_W:1];
            if (ok2) s2_d = shreg_q[DATA_W:1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            chan_q    <= 1'b0;
            per_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            frame1_q  <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            err_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            cs1_n_q   <= 1'b1;
            cs2_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            per_q     <= per_d;
            bit_cnt_q <= bit_cnt_d;
            if (sclk_rise) shreg_q <= {shreg_q[FRAME_BITS-2:0], sdo_i};
            if ((state_q == ST_CS_HOLD) && !chan_q) frame1_q <= shreg_q;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            cs1_n_q   <= cs1_n_d;
            cs2_n_q   <= cs2_n_d;
        end
    end

    assign cs1_n_o  = cs1_n_q;
    assign cs2_n_o  = cs2_n_q;
    assign s1_o     = s1_q;
    assign s2_o     = s2_q;
    assign err_ch_o = err_q;
    assign valid_o  = valid_q;
    assign busy_o   = busy_q;

endmodule
